// File: rtl/ula_74181_seq_if.sv
// ula_74181_seq_if: start/busy/done bus of the sliced 74181 ALU; ovf/neg exist only with ULA_FLAGS_EN.
interface ula_74181_seq_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       s;
    logic             m;
    logic             c_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] f;
    logic             c_out;
    logic             a_eq_b;
    logic             zero;
`ifdef ULA_FLAGS_EN
    logic             ovf;
    logic             neg;
`endif
    modport master (
        output start, a, b, s, m, c_in,
        input  busy, done, f, c_out, a_eq_b, zero
`ifdef ULA_FLAGS_EN
        , input ovf, neg
`endif
    );
    modport slave (
        input  start, a, b, s, m, c_in,
        output busy, done, f, c_out, a_eq_b, zero
`ifdef ULA_FLAGS_EN
        , output ovf, neg
`endif
    );
endinterface

// File: rtl/ula_74181_seq.sv
// ula_74181_seq: WIDTH-bit ALU running one 74181 slice per clock, carry rippled through a register.
// Optional ovf/neg flag outputs are built when ULA_FLAGS_EN is defined.
module ula_74181_seq #(
    parameter int WIDTH = 8
) (
    input logic            clk,
    input logic            rst,
    ula_74181_seq_if.slave bus
);
    localparam int NSLICE = WIDTH / 4;
    localparam int IW = NSLICE > 1 ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] a_q, b_q, f_q, f_d;
    logic [3:0]       s_q;
    logic             m_q;
    logic             cy_q, cy_d, eq_q, eq_d;
    logic             c_out_q, c_out_d, a_eq_b_q, a_eq_b_d, zero_q, zero_d;
    logic             accept, last;
    logic [3:0]       as, bs, lg, x, y;
    logic [4:0]       sum;
`ifdef ULA_FLAGS_EN
    logic             ovf_q, ovf_d, neg_q, neg_d;
    logic [3:0]       sum3;
`endif

    assign accept = bus.start && state_q != CALC;
    assign last   = idx_q == IW'(NSLICE - 1);
    assign as     = a_q[4*idx_q +: 4];
    assign bs     = b_q[4*idx_q +: 4];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cy_q     <= 1'b0;
            eq_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            s_q      <= '0;
            m_q      <= 1'b0;
            f_q      <= '0;
            c_out_q  <= 1'b0;
            a_eq_b_q <= 1'b0;
            zero_q   <= 1'b0;
`ifdef ULA_FLAGS_EN
            ovf_q    <= 1'b0;
            neg_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cy_q     <= cy_d;
            eq_q     <= eq_d;
            f_q      <= f_d;
            c_out_q  <= c_out_d;
            a_eq_b_q <= a_eq_b_d;
            zero_q   <= zero_d;
`ifdef ULA_FLAGS_EN
            ovf_q    <= ovf_d;
            neg_q    <= neg_d;
`endif
            if (accept) begin
                a_q <= bus.a;
                b_q <= bus.b;
                s_q <= bus.s;
                m_q <= bus.m;
            end
        end
    end

    always_comb begin
        state_d = accept ? CALC : (state_q == CALC ? (last ? DONE : CALC) : IDLE);
    end

    always_comb begin
        lg = 4'h0;
        case (s_q)
            4'h0: lg = ~as;
            4'h1: lg = ~(as | bs);
            4'h2: lg = ~as & bs;
            4'h3: lg = 4'h0;
            4'h4: lg = ~(as & bs);
            4'h5: lg = ~bs;
            4'h6: lg = as ^ bs;
            4'h7: lg = as & ~bs;
            4'h8: lg = ~as | bs;
            4'h9: lg = ~(as ^ bs);
            4'hA: lg = bs;
            4'hB: lg = as & bs;
            4'hC: lg = 4'hF;
            4'hD: lg = as | ~bs;
            4'hE: lg = as | bs;
            default: lg = as;
        endcase
    end

    // "-1" terms use Y = 1111 so the borrow ripples correctly across slices
    always_comb begin
        {x, y} = 8'h00;
        case (s_q)
            4'h0: {x, y} = {as, 4'h0};
            4'h1: {x, y} = {as | bs, 4'h0};
            4'h2: {x, y} = {as | ~bs, 4'h0};
            4'h3: {x, y} = {4'h0, 4'hF};
            4'h4: {x, y} = {as, as & ~bs};
            4'h5: {x, y} = {as | bs, as & ~bs};
            4'h6: {x, y} = {as, ~bs};
            4'h7: {x, y} = {as & ~bs, 4'hF};
            4'h8: {x, y} = {as, as & bs};
            4'h9: {x, y} = {as, bs};
            4'hA: {x, y} = {as | ~bs, as & bs};
            4'hB: {x, y} = {as & bs, 4'hF};
            4'hC: {x, y} = {as, as};
            4'hD: {x, y} = {as | bs, as};
            4'hE: {x, y} = {as | ~bs, as};
            default: {x, y} = {as, 4'hF};
        endcase
        sum = {1'b0, x} + {1'b0, y} + {4'h0, cy_q};
    end

`ifdef ULA_FLAGS_EN
    assign sum3 = {1'b0, x[2:0]} + {1'b0, y[2:0]} + {3'h0, cy_q};
`endif

    always_comb begin
        idx_d    = idx_q;
        cy_d     = cy_q;
        eq_d     = eq_q;
        f_d      = f_q;
        c_out_d  = c_out_q;
        a_eq_b_d = a_eq_b_q;
        zero_d   = zero_q;
`ifdef ULA_FLAGS_EN
        ovf_d    = ovf_q;
        neg_d    = neg_q;
`endif
        if (accept) begin
            idx_d = '0;
            cy_d  = bus.c_in & ~bus.m;
            eq_d  = 1'b1;
            f_d   = '0;
        end else if (state_q == CALC) begin
            f_d[4*idx_q +: 4] = m_q ? lg : sum[3:0];
            cy_d  = m_q ? 1'b0 : sum[4];
            eq_d  = eq_q & (as == bs);
            idx_d = idx_q + 1'b1;
            if (last) begin
                c_out_d  = cy_d;
                a_eq_b_d = eq_d;
                zero_d   = f_d == '0;
`ifdef ULA_FLAGS_EN
                ovf_d    = m_q ? 1'b0 : sum3[3] ^ sum[4];
                neg_d    = f_d[WIDTH-1];
`endif
            end
        end
    end

    assign bus.busy   = state_q == CALC;
    assign bus.done   = state_q == DONE;
    assign bus.f      = f_q;
    assign bus.c_out  = c_out_q;
    assign bus.a_eq_b = a_eq_b_q;
    assign bus.zero   = zero_q;
`ifdef ULA_FLAGS_EN
    assign bus.ovf    = ovf_q;
    assign bus.neg    = neg_q;
`endif
endmodule

// File: tb/tb_ula_74181_seq.sv
// tb_ula_74181_seq: directed vectors for 8- and 16-bit instances, scoreboard queues checked on done.
module tb_ula_74181_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ula_74181_seq_if #(.WIDTH(8))  bus8 ();
    ula_74181_seq_if #(.WIDTH(16)) bus16 ();

    ula_74181_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));
    ula_74181_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));

    typedef struct {
        logic [15:0] f;
        logic        c, eq, z, ovf, neg;
    } exp_t;

    exp_t q8[$], q16[$];
    exp_t e8, e16;
    int   tests = 0, fails = 0, done8_cnt = 0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus8.done === 1'b1) begin
            done8_cnt++;
            chk("done8 pending", q8.size() != 0, 1);
            if (q8.size() != 0) begin
                e8 = q8.pop_front();
                chk("f8", bus8.f, e8.f);
                chk("c_out8", bus8.c_out, e8.c);
                chk("a_eq_b8", bus8.a_eq_b, e8.eq);
                chk("zero8", bus8.zero, e8.z);
`ifdef ULA_FLAGS_EN
                chk("ovf8", bus8.ovf, e8.ovf);
                chk("neg8", bus8.neg, e8.neg);
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (bus16.done === 1'b1) begin
            chk("done16 pending", q16.size() != 0, 1);
            if (q16.size() != 0) begin
                e16 = q16.pop_front();
                chk("f16", bus16.f, e16.f);
                chk("c_out16", bus16.c_out, e16.c);
                chk("a_eq_b16", bus16.a_eq_b, e16.eq);
                chk("zero16", bus16.zero, e16.z);
`ifdef ULA_FLAGS_EN
                chk("ovf16", bus16.ovf, e16.ovf);
                chk("neg16", bus16.neg, e16.neg);
`endif
            end
        end
    end

    task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s,
                          input logic m, input logic cin);
        bus8.a = a; bus8.b = b; bus8.s = s; bus8.m = m; bus8.c_in = cin;
    endtask

    task automatic wait_done8(input int n0, input int lat);
        int n = n0;
        while (bus8.done !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency8", n, lat);
    endtask

    // gap=1 starts from IDLE; gap=0 starts in the DONE cycle of the previous op
    task automatic op8(input bit gap, input logic [7:0] a, input logic [7:0] b, input logic [3:0] s,
                       input logic m, input logic cin, input logic [7:0] f,
                       input logic c, input logic eq, input logic z, input logic ovf, input logic neg);
        exp_t e;
        if (gap) begin
            @(posedge clk); #1;
        end
        e.f = {8'h00, f}; e.c = c; e.eq = eq; e.z = z; e.ovf = ovf; e.neg = neg;
        q8.push_back(e);
        drive8(a, b, s, m, cin);
        bus8.start = 1'b1;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        chk("busy8 after start", bus8.busy, 1);
        wait_done8(0, 2);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n, d0;
        exp_t e;
        rst = 1'b1;
        bus8.start = 1'b0; drive8(8'h00, 8'h00, 4'h0, 1'b0, 1'b0);
        bus16.start = 1'b0; bus16.a = '0; bus16.b = '0; bus16.s = '0; bus16.m = 1'b0; bus16.c_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst busy", bus8.busy, 0);
        chk("rst done", bus8.done, 0);
        chk("rst f", bus8.f, 0);
        chk("rst flags", {bus8.c_out, bus8.a_eq_b, bus8.zero}, 0);
        rst = 1'b0;

        op8(1, 8'h7F, 8'h01, 4'b1001, 0, 0, 8'h80, 0, 0, 0, 1, 1);
        op8(1, 8'h05, 8'h07, 4'b0110, 0, 1, 8'hFE, 0, 0, 0, 0, 1);
        op8(0, 8'h07, 8'h05, 4'b0110, 0, 1, 8'h02, 1, 0, 0, 0, 0);
        op8(1, 8'h12, 8'h34, 4'b0011, 0, 0, 8'hFF, 0, 0, 0, 0, 1);
        op8(0, 8'h12, 8'h34, 4'b0011, 0, 1, 8'h00, 1, 0, 1, 0, 0);
        op8(1, 8'hA5, 8'h0F, 4'b0110, 1, 1, 8'hAA, 0, 0, 0, 0, 1);
        op8(0, 8'h3C, 8'h3C, 4'b0011, 1, 1, 8'h00, 0, 1, 1, 0, 0);
        op8(1, 8'hFF, 8'h01, 4'b1001, 0, 0, 8'h00, 1, 0, 1, 0, 0);

        // start pulsed during CALC with other operands must be ignored
        @(posedge clk); #1;
        e.f = 16'h0030; e.c = 0; e.eq = 0; e.z = 0; e.ovf = 0; e.neg = 0;
        q8.push_back(e);
        d0 = done8_cnt;
        drive8(8'h10, 8'h20, 4'b1001, 0, 0);
        bus8.start = 1'b1;
        @(posedge clk); #1;
        drive8(8'hFF, 8'hFF, 4'b0000, 1, 1);
        @(posedge clk); #1;
        bus8.start = 1'b0;
        wait_done8(1, 2);
        repeat (4) @(posedge clk);
        #1;
        chk("ignored start done count", done8_cnt - d0, 1);
        chk("ignored start idle", bus8.busy, 0);

        // reset in the first CALC cycle aborts with no done pulse
        d0 = done8_cnt;
        drive8(8'h01, 8'h02, 4'b1001, 0, 0);
        bus8.start = 1'b1;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort busy", bus8.busy, 0);
        chk("abort done", bus8.done, 0);
        chk("abort f", bus8.f, 0);
        chk("abort flags", {bus8.c_out, bus8.a_eq_b, bus8.zero}, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("abort no done", done8_cnt - d0, 0);

        // 16-bit regression: carry ripples through four slices
        e.f = 16'h0000; e.c = 1; e.eq = 0; e.z = 1; e.ovf = 0; e.neg = 0;
        q16.push_back(e);
        bus16.a = 16'hFFFF; bus16.b = 16'h0001; bus16.s = 4'b1001; bus16.m = 1'b0; bus16.c_in = 1'b0;
        bus16.start = 1'b1;
        @(posedge clk); #1;
        bus16.start = 1'b0;
        n = 0;
        while (bus16.done !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency16", n, 4);
        repeat (3) @(posedge clk);
        #1;
        chk("q8 drained", q8.size(), 0);
        chk("q16 drained", q16.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
